pmod_in_reader: RTL

- Input-side counterpart to the PMOD LED driver: samples the 32 PMOD pins configured as inputs (buttons or switches).
- Synchronizes and debounces every pin, and produces a debounced level plus one-cycle rise/fall pulses per pin.
- Accumulates changes into a change mask that is delivered to a consumer over a valid/ready handshake.
- Sits between the PMOD connector pins and the board control logic or LED display.

---
 rtl/pmod_pkg.sv | 14 +
 rtl/pmod_debounce_bit.sv | 71 +++++++
 rtl/pmod_in_reader.sv | 92 +++++++++
 3 files changed

// File: rtl/pmod_pkg.sv
// Shared PMOD definitions: four 8-pin connectors viewed as one 32-bit bus.
// Used by both the LED driver and the input reader.
package pmod_pkg;

  localparam int NBITS = 32;

  typedef logic [3:0][7:0] pmod_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pmod_debounce_bit.sv
// One-pin debouncer: 2-flop synchronizer, tick-gated stability counter,
// debounced level and registered one-cycle rise/fall pulses.
module pmod_debounce_bit
  import pmod_pkg::*;
#(
  parameter int NSTABLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic pin,
  output logic db_level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_width(NSTABLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(NSTABLE - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    meta_d = pin;
    sync_d = meta_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (tick) begin
      if (sync_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // Pin has disagreed for NSTABLE consecutive ticks: accept it.
        cnt_d  = '0;
        db_d   = sync_q;
        rise_d = sync_q;
        fall_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_level = db_q;
  assign rise     = rise_q;
  assign fall     = fall_q;

endmodule

// File: rtl/pmod_in_reader.sv
// Debounced PMOD input reader: shared sample tick, 32 per-pin debouncers and a
// sticky change mask delivered over a valid/ready handshake.
module pmod_in_reader
  import pmod_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int NSTABLE  = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  pmod_t pmod_in,
  output pmod_t db_level,
  output pmod_t rise,
  output pmod_t fall,
  output logic  evt_valid,
  output pmod_t evt_data,
  input  logic  evt_ready
);

  localparam int            TW        = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [NBITS-1:0] pin_flat, db_flat, rise_flat, fall_flat;
  logic [NBITS-1:0] chg, merged;
  logic [NBITS-1:0] pend_q, pend_d;
  logic [NBITS-1:0] evt_data_q, evt_data_d;
  logic             evt_valid_q, evt_valid_d;
  logic             load;

  assign tick = (tick_cnt_q == '0);

  always_comb begin
    tick_cnt_d = tick ? TICK_LAST : tick_cnt_q - 1'b1;
  end

  assign pin_flat = pmod_in;

  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_pin
      pmod_debounce_bit #(.NSTABLE(NSTABLE)) u_db (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .pin      (pin_flat[gi]),
        .db_level (db_flat[gi]),
        .rise     (rise_flat[gi]),
        .fall     (fall_flat[gi])
      );
    end
  endgenerate

  // Changes arriving while the word is accepted fold into the next word.
  always_comb begin
    chg         = rise_flat | fall_flat;
    merged      = pend_q | chg;
    load        = (~evt_valid_q | evt_ready) && (merged != '0);
    pend_d      = merged;
    evt_data_d  = evt_data_q;
    evt_valid_d = evt_valid_q;
    if (load) begin
      evt_data_d  = merged;
      evt_valid_d = 1'b1;
      pend_d      = '0;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= TICK_LAST;
      pend_q      <= '0;
      evt_data_q  <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      pend_q      <= pend_d;
      evt_data_q  <= evt_data_d;
      evt_valid_q <= evt_valid_d;
    end
  end

  assign db_level  = db_flat;
  assign rise      = rise_flat;
  assign fall      = fall_flat;
  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;

endmodule
